ifu_prefetch: RTL
=================

# ifu_prefetch

Parametrised instruction-fetch unit with a sequential prefetch queue. It issues AXI4-lite read requests for consecutive PCs, buffers up to `FIFO_DEPTH` fetched `{inst, pc}` pairs, and presents them to the IDU over a valid/ready handshake. It sits between the AXI4-lite instruction memory port and the IDU, and supports redirect/flush and access-fault reporting, which the single-shot fetcher does not have.

## Interface
- `WIDTH`, 32: address and instruction width.
- `FIFO_DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `redirect_valid` input 1: flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc` input WIDTH: new fetch address, word-aligned.
- `ifu_valid` output 1: queue head valid.
- `ifu_data` output 2*WIDTH: head entry `{inst, pc}`.
- `ifu_err` output 1: head entry carries an access fault; `inst` is 0.
- `idu_ready` input 1: IDU accepts head.
- `ARADDR` output WIDTH, `ARVALID` output 1, `ARREADY` input 1: AXI4-lite read address.
- `RDATA` input WIDTH, `RRESP` input 2, `RVALID` input 1, `RREADY` output 1: AXI4-lite read data.

## Operation
- FSM states `S_IDLE`, `S_ADDR`, `S_DATA`. One outstanding read at most.
- `S_IDLE`: go to `S_ADDR` when `count < FIFO_DEPTH`, `!halted`, and `!redirect_valid`. On entry, latch `ar_addr <= fetch_pc`.
- `S_ADDR`: `ARVALID=1` and `ARADDR=ar_addr`, both held stable until `ARREADY`. On handshake go to `S_DATA`.
- `S_DATA`: `RREADY=1` (a slot is reserved). On `RVALID`:
  - If `drop` is set, discard the beat and clear `drop`.
  - Otherwise enqueue `{RDATA, ar_addr}` with `err = (RRESP != 0)`. Set `fetch_pc <= ar_addr + 4` on OKAY. On error, store `inst = 0` and set `halted`.
  - Go to `S_IDLE`.
- Dequeue when `ifu_valid & idu_ready`.
- `redirect_valid` has priority over everything else in the same cycle:
  - Clear the queue, `count`, and `halted`; set `fetch_pc <= redirect_pc`.
  - If state is `S_ADDR` or `S_DATA`, set `drop`. The AXI transaction still completes legally.
  - A concurrent enqueue or dequeue is ignored.
- Simultaneous enqueue and dequeue with a full queue is legal: `count` is unchanged.
- `halted` blocks new requests only. Entries already queued drain normally, including the faulting entry.
- Address arithmetic is modulo 2^WIDTH: `32'hFFFF_FFFC + 4` wraps to 0.

## Timing
- Reset values: `ARVALID=0`, `RREADY=0`, `ifu_valid=0`, `ifu_err=0`, `ifu_data=0`. Also `state=S_IDLE`, `fetch_pc=RESET_PC`, `count=0`, `drop=0`, `halted=0`.
- `rst` asserted mid-transaction aborts immediately with the same values. The bench re-resets the slave.
- `ARVALID` and `RREADY` are decoded from registered state, with no combinational path from AXI inputs.
- `ifu_valid`, `ifu_data`, and `ifu_err` come from registered queue storage. There is no combinational path from `RDATA` or `idu_ready`.
- Latency with a zero-wait slave (`ARREADY=1`, `RVALID` in the same cycle as `RREADY`):
  - Cycle 1 after reset release: `ARVALID`.
  - Cycle 2: R handshake.
  - Cycle 3: `ifu_valid`.
- Sustained throughput is 1 instruction per 3 cycles with a zero-wait slave.
- A redirect in cycle N takes effect at cycle N+1. The first request to `redirect_pc` is issued at N+1 if the FSM is idle, otherwise after the dropped beat returns.
- `ifu_valid` is held with stable data until `idu_ready`.

## Structure
- Package `ifu_pkg`:
  - `ifu_state_t` (`S_IDLE`, `S_ADDR`, `S_DATA`).
  - `ifu_entry_t` struct `{err, inst, pc}`.
  - `AXI_RESP_OKAY` constant, 2'b00.
- Sub-module `ifu_fifo`: parametrised synchronous FIFO with `DEPTH` and entry type. It provides registered head, `count`, a `clear` input, and wrap-around pointers of `log2(DEPTH)+1` bits.
- The top level holds the FSM, `fetch_pc`, `ar_addr`, `drop`, and `halted`.

## Test plan
- Reset, zero-wait slave returning `RDATA = addr ^ 32'hA5A5_A5A5`, `idu_ready=1`:
  - Entries `pc = 8000_0000, 8000_0004, 8000_0008` appear with matching `inst`.
  - The first `ifu_valid` is on cycle 3.
- `idu_ready=0` with `FIFO_DEPTH=4`:
  - Exactly 4 AR handshakes occur, then `ARVALID` stays 0.
  - Raising `idu_ready` for 1 cycle causes exactly one more request.
- Redirect to `8000_0100` while in `S_DATA` with a 3-cycle `RVALID` delay:
  - The returning beat for the old PC is discarded and the queue is empty.
  - The next entry has `pc = 8000_0100`.
- Slave returns `RRESP=2'b10` at `8000_0008`:
  - Entry `{err=1, inst=0, pc=8000_0008}` is delivered and no further AR occurs.
  - A redirect to `8000_0000` resumes fetching.
- Simultaneous enqueue, dequeue, and redirect in one cycle: the queue is empty next cycle and `fetch_pc = redirect_pc`.
- Random `ARREADY`/`RVALID` stalls (10k cycles): `ARADDR` is stable while `ARVALID` is high, and the delivered PC sequence is strictly +4 between redirects.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         IFU_XLEN      = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } ifu_state_t;

    // Default-width queue entry; the top level builds its own WIDTH-sized twin.
    typedef struct packed {
        logic                err;
        logic [IFU_XLEN-1:0] inst;
        logic [IFU_XLEN-1:0] pc;
    } ifu_entry_t;

    // Any response other than OKAY is treated as an access fault.
    function automatic logic is_fault(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch queue with wrap-bit pointers, flush input and
// a head output that reads as all-zero while the queue is empty.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ifu_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    T            r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop_ok;
    logic        w_push_ok;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop_ok  = i_pop && !w_empty;
    // A full queue may still accept a write when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // Pointer update; a flush discards everything including same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Entry storage; no reset needed because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear && !rst) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    // Head presentation straight from stored entries.
    always_comb begin
        o_head = '0;
        if (!w_empty) o_head = r_mem[r_rptr[AW-1:0]];
    end

    assign o_valid = !w_empty;
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: AXI4-lite read master feeding a
// small queue of {inst, pc} entries toward the decoder, with redirect
// and access-fault handling.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               ifu_valid,
    output logic [2*WIDTH-1:0] ifu_data,
    output logic               ifu_err,
    input  logic               idu_ready,
    output logic [WIDTH-1:0]   ARADDR,
    output logic               ARVALID,
    input  logic               ARREADY,
    input  logic [WIDTH-1:0]   RDATA,
    input  logic [1:0]         RRESP,
    input  logic               RVALID,
    output logic               RREADY
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] pc;
    } entry_t;

    ifu_state_t       r_state;
    ifu_state_t       w_state_next;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_ar_addr;
    logic             r_drop;
    logic             r_halted;
    logic             w_r_hs;
    logic             w_fault;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    entry_t           w_push_entry;
    entry_t           w_head;
    logic [CW-1:0]    w_count;

    assign w_r_hs  = (r_state == S_DATA) && RVALID;
    assign w_fault = is_fault(RRESP);
    assign w_push  = w_r_hs && !r_drop && !redirect_valid;
    assign w_pop   = idu_ready && !redirect_valid;
    assign w_issue = (r_state == S_IDLE) && (w_state_next == S_ADDR);

    // Build the entry for a returning beat; faulting beats carry no instruction.
    always_comb begin
        w_push_entry.err  = w_fault;
        w_push_entry.inst = w_fault ? '0 : RDATA;
        w_push_entry.pc   = r_ar_addr;
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_valid (ifu_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign ifu_data = {w_head.inst, w_head.pc};
    assign ifu_err  = w_head.err;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state: a request is only started when a queue slot is free.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if ((w_count < CW'(FIFO_DEPTH)) && !r_halted && !redirect_valid)
                         w_state_next = S_ADDR;
            S_ADDR:  if (ARREADY) w_state_next = S_DATA;
            S_DATA:  if (RVALID)  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs decoded purely from the registered state.
    always_comb begin
        ARVALID = (r_state == S_ADDR);
        RREADY  = (r_state == S_DATA);
    end

    assign ARADDR = r_ar_addr;

    // Fetch PC, request address, drop and halt bookkeeping; redirect wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_ar_addr  <= '0;
            r_drop     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            if (w_issue) r_ar_addr <= r_fetch_pc;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_halted   <= 1'b0;
                // Only a beat that is still to come must be swallowed; a beat
                // returning this very cycle is consumed and ignored right here.
                r_drop     <= (r_state == S_ADDR) || ((r_state == S_DATA) && !RVALID);
            end else if (w_r_hs) begin
                if (r_drop)       r_drop     <= 1'b0;
                else if (w_fault) r_halted   <= 1'b1;
                else              r_fetch_pc <= r_ar_addr + WIDTH'(4);
            end
        end
    end

endmodule
